// File: rtl/wb_write_data_stage.sv
// wb_write_data_stage
//
// Registered write-back data stage for the multicycle MIPS datapath. One of
// NSRC packed source buses is selected, the requested byte or halfword lane
// is extracted and zero- or sign-extended, and the result is registered with
// the destination register index and the register-file write enable.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   src_bus    NSRC packed sources, source i at [i*DATA_W +: DATA_W]
//   sel        source select (values >= NSRC select zero and are flagged)
//   ext_mode   000 word, 001 lbu, 010 lb, 011 lhu, 100 lh, others word
//   byte_off   byte lane within the selected word
//   dest_in    destination register index
//   we_in      write request
//   valid_in   input transfer valid
//   stall      hold the output stage
//   flush      kill the output stage (wins over stall)
//   wdata      registered write data
//   dest_out   registered destination register
//   we_out     register-file write enable (qualify with !stall)
//   valid_out  output stage holds a transfer
//   sel_err    sticky flag: an out-of-range select was captured
//   align_err  one-cycle pulse after capturing a misaligned halfword
//   wb_count   committed-write counter, wraps at 16 bits

module wb_write_data_stage #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 8,
  parameter int SEL_W  = $clog2(NSRC),
  parameter int REG_W  = 5,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NSRC*DATA_W-1:0] src_bus,
  input  logic [SEL_W-1:0]       sel,
  input  logic [2:0]             ext_mode,
  input  logic [OFF_W-1:0]       byte_off,
  input  logic [REG_W-1:0]       dest_in,
  input  logic                   we_in,
  input  logic                   valid_in,
  input  logic                   stall,
  input  logic                   flush,
  output logic [DATA_W-1:0]      wdata,
  output logic [REG_W-1:0]       dest_out,
  output logic                   we_out,
  output logic                   valid_out,
  output logic                   sel_err,
  output logic                   align_err,
  output logic [15:0]            wb_count
);

  localparam int NBYTE = DATA_W / 8;
  localparam int NHALF = DATA_W / 16;

  logic [DATA_W-1:0] sel_word;
  logic              sel_bad;
  logic [OFF_W-1:0]  half_idx;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic              is_half;
  logic              misaligned;
  logic [DATA_W-1:0] ext_data;
  logic              we_next;

  // Source mux. An out-of-range select matches no source and yields zero;
  // the extra leading zero bit keeps the range compare legal when NSRC is a
  // power of two.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_word = src_bus[i*DATA_W +: DATA_W];
      end
    end
    sel_bad = ({1'b0, sel} >= (SEL_W+1)'(NSRC));
  end

  // Lane extraction. The halfword lane ignores byte_off[0], so a misaligned
  // halfword still returns the aligned pair it falls in.
  always_comb begin
    half_idx  = byte_off >> 1;
    lane_byte = '0;
    lane_half = '0;
    for (int b = 0; b < NBYTE; b++) begin
      if (byte_off == OFF_W'(b)) begin
        lane_byte = sel_word[b*8 +: 8];
      end
    end
    for (int h = 0; h < NHALF; h++) begin
      if (half_idx == OFF_W'(h)) begin
        lane_half = sel_word[h*16 +: 16];
      end
    end
  end

  // Extension. Sized casts of signed values sign-extend, which avoids
  // zero-width replications when DATA_W is 16.
  always_comb begin
    is_half    = (ext_mode == 3'b011) || (ext_mode == 3'b100);
    misaligned = is_half && byte_off[0];
    case (ext_mode)
      3'b001:  ext_data = DATA_W'(lane_byte);
      3'b010:  ext_data = DATA_W'($signed(lane_byte));
      3'b011:  ext_data = DATA_W'(lane_half);
      3'b100:  ext_data = DATA_W'($signed(lane_half));
      default: ext_data = sel_word;
    endcase
    we_next = we_in && (dest_in != '0) && !sel_bad && !misaligned;
  end

  // Output register. The counter sees the write enable currently presented
  // to the register file, so each write is counted once, on the cycle it
  // actually commits (i.e. when not stalled). align_err drops on every edge
  // that is not a misaligned capture, which keeps it a single-cycle pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdata     <= '0;
      dest_out  <= '0;
      we_out    <= 1'b0;
      valid_out <= 1'b0;
      sel_err   <= 1'b0;
      align_err <= 1'b0;
      wb_count  <= '0;
    end else begin
      if (we_out && !stall) begin
        wb_count <= wb_count + 16'd1;
      end
      align_err <= 1'b0;
      if (flush) begin
        valid_out <= 1'b0;
        we_out    <= 1'b0;
      end else if (!stall) begin
        valid_out <= valid_in;
        if (valid_in) begin
          wdata     <= ext_data;
          dest_out  <= dest_in;
          we_out    <= we_next;
          align_err <= misaligned;
          if (sel_bad) begin
            sel_err <= 1'b1;
          end
        end else begin
          we_out <= 1'b0;
        end
      end
    end
  end

endmodule
